uart_tx_arbiter: RTL and testbench

Round-robin, message-locked arbiter sharing one `uart_tx` transmit queue between `NUM_REQ` byte-stream requesters, e.g. core console, debug monitor and the QSPI status reporter. It sits directly in front of `uart_tx` and drives its `we_i`/`data_i` while obeying `full_o`. A grant is held until the requester marks the end of its message, so message bytes are never interleaved. A configurable burst cap bounds how long any one requester can hold the UART.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding one uart_tx write port from NUM_REQ byte streams.
// Optional idle-lock timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 uart_full_i,
    output logic                 uart_we_o,
    output logic [7:0]           uart_data_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int                IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0]        BURST_LIM   = 9'(MAX_BURST);
    localparam logic [16:0]       TIMEOUT_LIM = 17'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0]  LAST_RST    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic [IDX_W-1:0]   last_grant_r, last_grant_s;
    logic [7:0]         burst_cnt_r, burst_cnt_s;
    logic               timeout_r, timeout_s;

    logic               owner_valid_s;
    logic               owner_last_s;
    logic [7:0]         owner_data_s;
    logic               locked_s;
    logic               accept_s;
    logic               cap_hit_s;
    logic               idle_hit_s;
    logic [IDX_W-1:0]   pick_s;

    // First valid requester strictly after 'last', wrapping; lower distance wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (valid[cand]) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (idx == IDX_W'(k)) begin
                oh[k] = 1'b1;
            end else begin
                oh[k] = 1'b0;
            end
        end
        return oh;
    endfunction

    assign pick_s    = rr_pick(req_valid_i, last_grant_r);
    assign locked_s  = (state_r == ST_LOCKED);
    assign accept_s  = locked_s & owner_valid_s & ~uart_full_i;
    assign cap_hit_s = (({1'b0, burst_cnt_r} + 9'd1) == BURST_LIM);

    // AND-OR select of the owner's lane using the one-hot grant
    always_comb begin
        owner_valid_s = 1'b0;
        owner_last_s  = 1'b0;
        owner_data_s  = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_valid_s = owner_valid_s | (grant_r[k] & req_valid_i[k]);
            owner_last_s  = owner_last_s  | (grant_r[k] & req_last_i[k]);
            owner_data_s  = owner_data_s  | ({8{grant_r[k]}} & req_data_i[8*k +: 8]);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] idle_cnt_r, idle_cnt_s;

    // Idle-lock counter: runs only while the owner is silent and the UART could accept
    always_comb begin
        idle_cnt_s = idle_cnt_r;
        idle_hit_s = 1'b0;
        if (!locked_s || accept_s) begin
            idle_cnt_s = 16'd0;
        end else if (!owner_valid_s && !uart_full_i) begin
            idle_cnt_s = idle_cnt_r + 16'd1;
            idle_hit_s = (({1'b0, idle_cnt_r} + 17'd1) == TIMEOUT_LIM);
        end else begin
            idle_cnt_s = idle_cnt_r;
        end
    end

    // Idle-lock counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_r <= 16'd0;
        end else begin
            idle_cnt_r <= idle_cnt_s;
        end
    end
`else
    // Lock is never revoked for inactivity in this build
    assign idle_hit_s = 1'b0 & (TIMEOUT_LIM != 17'd0);
`endif

    // Next-state logic for arbitration, lock release and burst counting
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        burst_cnt_s  = burst_cnt_r;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    state_s      = ST_LOCKED;
                    grant_s      = to_onehot(pick_s);
                    last_grant_s = pick_s;
                    burst_cnt_s  = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s) begin
                    burst_cnt_s = burst_cnt_r + 8'd1;
                    if (owner_last_s || cap_hit_s) begin
                        state_s = ST_IDLE;
                        grant_s = {NUM_REQ{1'b0}};
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end else if (idle_hit_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = {NUM_REQ{1'b0}};
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            grant_r      <= {NUM_REQ{1'b0}};
            last_grant_r <= LAST_RST;
            burst_cnt_r  <= 8'd0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            burst_cnt_r  <= burst_cnt_s;
            timeout_r    <= timeout_s;
        end
    end

    // Write path is combinational so uart_tx samples at the same edge as the handshake
    assign req_ready_o = (locked_s && !uart_full_i) ? grant_r : {NUM_REQ{1'b0}};
    assign uart_we_o   = accept_s;
    assign uart_data_o = locked_s ? owner_data_s : 8'h00;
    assign grant_o     = grant_r;
    assign busy_o      = locked_s;
    assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a message-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int TO = 1024;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [NR-1:0]   req_valid_i;
    logic [8*NR-1:0] req_data_i;
    logic [NR-1:0]   req_last_i;
    logic [NR-1:0]   req_ready_o;
    logic            uart_full_i;
    logic            uart_we_o;
    logic [7:0]      uart_data_o;
    logic [NR-1:0]   grant_o;
    logic            busy_o;
    logic            timeout_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .uart_full_i(uart_full_i),
        .uart_we_o(uart_we_o), .uart_data_o(uart_data_o),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  gen_q [NR][$];
    logic [8:0]  exp_q [NR][$];
    logic [11:0] log_q [$];
    logic [NR-1:0] cur_valid;
    logic [NR-1:0] cur_last;
    logic [7:0]    cur_data [NR];
    bit auto_gen, rand_gap, full_mode, full_force;

    int m_owner, m_last, m_cnt, m_idle;
    bit m_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_log(input string name, input int idx, input int owner, input int data);
        logic [31:0] act;
        act = (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hFFFF_FFFF;
        chk(name, act, 32'({owner[3:0], data[7:0]}));
    endtask

    task automatic drive_pins();
        for (int k = 0; k < NR; k++) begin
            req_valid_i[k]       = cur_valid[k];
            req_last_i[k]        = cur_last[k];
            req_data_i[8*k +: 8] = cur_data[k];
        end
    endtask

    task automatic gen_msg(input int k);
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++)
            gen_q[k].push_back({1'(i == len - 1), 8'($urandom_range(0, 255))});
    endtask

    function automatic int pending();
        int p = 0;
        for (int k = 0; k < NR; k++) p += gen_q[k].size() + int'(cur_valid[k]);
        return p;
    endfunction

    // One clock: retire accepted bytes, present new ones, choose the full level
    task automatic step_cycle();
        logic [NR-1:0] acc;
        logic [8:0]    e;
        @(negedge clk);
        acc = req_valid_i & req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) cur_valid[k] = 1'b0;
            if (auto_gen && !cur_valid[k] && gen_q[k].size() == 0 && $urandom_range(0, 7) == 0)
                gen_msg(k);
            if (!cur_valid[k] && gen_q[k].size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
                e = gen_q[k].pop_front();
                cur_valid[k] = 1'b1;
                cur_last[k]  = e[8];
                cur_data[k]  = e[7:0];
                exp_q[k].push_back(e);
            end
        end
        uart_full_i = full_mode ? ($urandom_range(0, 3) == 0) : full_force;
        drive_pins();
    endtask

    task automatic flush_all();
        for (int k = 0; k < NR; k++) begin
            gen_q[k].delete();
            exp_q[k].delete();
            cur_data[k] = 8'h00;
        end
        cur_valid   = '0;
        cur_last    = '0;
        uart_full_i = 1'b0;
        log_q.delete();
        drive_pins();
    endtask

    // Reference model and monitor: predicts owner per cycle, pops expected bytes on writes
    always @(negedge clk) begin
        logic [NR-1:0] e_grant;
        logic [NR-1:0] e_ready;
        logic          e_we;
        logic [8:0]    e;
        int            c;
        bit            found;
        if (!rst_ni) begin
            m_owner = -1; m_last = NR - 1; m_cnt = 0; m_idle = 0; m_pulse = 0;
        end else begin
            e_grant = (m_owner < 0) ? '0 : NR'(1 << m_owner);
            e_ready = (m_owner >= 0 && !uart_full_i) ? e_grant : '0;
            e_we    = (m_owner >= 0) && req_valid_i[m_owner] && !uart_full_i;
            chk("grant",   32'(grant_o),     32'(e_grant));
            chk("busy",    32'(busy_o),      32'(m_owner >= 0));
            chk("ready",   32'(req_ready_o), 32'(e_ready));
            chk("we",      32'(uart_we_o),   32'(e_we));
            chk("timeout", 32'(timeout_o),   32'(m_pulse));
            m_pulse = 0;
            if (m_owner < 0) begin
                if (|req_valid_i) begin
                    found = 0;
                    for (int i = 1; i <= NR; i++) begin
                        c = (m_last + i) % NR;
                        if (!found && req_valid_i[c]) begin
                            found = 1;
                            m_owner = c;
                        end
                    end
                    m_last = m_owner; m_cnt = 0; m_idle = 0;
                end
            end else if (e_we) begin
                chk("write_pending", 32'(exp_q[m_owner].size() > 0), 32'd1);
                e = (exp_q[m_owner].size() > 0) ? exp_q[m_owner].pop_front() : 9'h100;
                chk("data", 32'(uart_data_o), 32'(e[7:0]));
                log_q.push_back({4'(m_owner), uart_data_o});
                m_cnt++;
                m_idle = 0;
                if (e[8] || m_cnt == MB) m_owner = -1;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!req_valid_i[m_owner] && !uart_full_i) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_owner = -1;
                    m_pulse = 1;
                end
            end
`endif
        end
    end

    initial begin
        rst_ni = 1'b0;
        auto_gen = 0; rand_gap = 0; full_mode = 0; full_force = 0;
        flush_all();
        #2;
        chk("rst_outputs", 32'({grant_o, req_ready_o, uart_we_o, uart_data_o, busy_o, timeout_o}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // single three-byte message from requester 2
        log_q.delete();
        gen_q[2].push_back(9'h041); gen_q[2].push_back(9'h042); gen_q[2].push_back(9'h143);
        repeat (8) step_cycle();
        chk("single_count", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) expect_log("single_byte", i, 2, 8'h41 + i);

        // asynchronous reset in the middle of a message
        log_q.delete();
        for (int i = 0; i < 4; i++) gen_q[1].push_back({1'(i == 3), 8'(8'h60 + i)});
        for (int i = 0; i < 20 && log_q.size() < 2; i++) step_cycle();
        chk("midrst_progress", 32'(log_q.size() >= 2), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_grant", 32'(grant_o), 32'd0);
        chk("midrst_wr", 32'({uart_we_o, uart_data_o, req_ready_o, busy_o, timeout_o}), 32'd0);
        flush_all();
        @(negedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        gen_q[0].push_back(9'h1C0); gen_q[3].push_back(9'h1C3);
        step_cycle(); step_cycle();
        chk("postrst_grant0", 32'(grant_o), 32'b0001);
        repeat (6) step_cycle();
        expect_log("postrst_b0", 0, 0, 8'hC0);
        expect_log("postrst_b1", 1, 3, 8'hC3);

        // burst cap: requester 1 streams without last while requester 2 waits
        log_q.delete();
        for (int i = 0; i < 6; i++) gen_q[1].push_back({1'b0, 8'(8'hA0 + i)});
        repeat (2) step_cycle();
        gen_q[2].push_back(9'h1B0);
        repeat (20) step_cycle();
        gen_q[1].push_back(9'h1FF);
        repeat (4) step_cycle();
        for (int i = 0; i < 4; i++) expect_log("burst_first", i, 1, 8'hA0 + i);
        expect_log("burst_other", 4, 2, 8'hB0);
        expect_log("burst_rest0", 5, 1, 8'hA4);
        expect_log("burst_rest1", 6, 1, 8'hA5);
        expect_log("burst_term",  7, 1, 8'hFF);

        // round-robin between requesters 0 and 1, two-byte messages
        log_q.delete();
        for (int m = 0; m < 2; m++) begin
            gen_q[0].push_back({1'b0, 8'(2*m)});      gen_q[0].push_back({1'b1, 8'(2*m + 1)});
            gen_q[1].push_back({1'b0, 8'(8'h10 + 2*m)}); gen_q[1].push_back({1'b1, 8'(8'h11 + 2*m)});
        end
        repeat (16) step_cycle();
        chk("rr_count", 32'(log_q.size()), 32'd8);
        for (int m = 0; m < 2; m++) begin
            expect_log("rr_r0", 4*m,     0, 2*m);
            expect_log("rr_r0", 4*m + 1, 0, 2*m + 1);
            expect_log("rr_r1", 4*m + 2, 1, 8'h10 + 2*m);
            expect_log("rr_r1", 4*m + 3, 1, 8'h11 + 2*m);
        end

        // back-pressure after the first byte
        log_q.delete();
        gen_q[3].push_back(9'h010); gen_q[3].push_back(9'h011); gen_q[3].push_back(9'h112);
        for (int i = 0; i < 10 && log_q.size() < 1; i++) step_cycle();
        chk("bp_start", 32'(log_q.size()), 32'd1);
        full_force = 1; uart_full_i = 1'b1;
        repeat (4) step_cycle();
        chk("bp_stall", 32'(log_q.size()), 32'd1);
        full_force = 0;
        repeat (6) step_cycle();
        chk("bp_count", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) expect_log("bp_byte", i, 3, 8'h10 + i);

        // randomized traffic with random gaps and random full
        log_q.delete();
        auto_gen = 1; rand_gap = 1; full_mode = 1;
        repeat (3000) step_cycle();
        auto_gen = 0; rand_gap = 0; full_mode = 0;
        for (int i = 0; i < 300 && pending() > 0; i++) step_cycle();
        chk("drain_done", 32'(pending()), 32'd0);
        repeat (3) step_cycle();
        chk("drain_exp_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);
        chk("drain_idle", 32'(grant_o), 32'd0);

        // owner goes silent after one byte of an unfinished message
        log_q.delete();
        gen_q[0].push_back(9'h05A);
        for (int i = 0; i < 20 && log_q.size() < 1; i++) step_cycle();
        chk("lock_first_byte", 32'(log_q.size()), 32'd1);
        repeat (2000) step_cycle();
`ifdef UART_ARB_TIMEOUT_EN
        chk("lock_after_idle", 32'(grant_o), 32'd0);
`else
        chk("lock_after_idle", 32'(grant_o), 32'b0001);
`endif
        gen_q[0].push_back(9'h15B);
        repeat (4) step_cycle();
        chk("lock_end_idle", 32'(grant_o), 32'd0);
        expect_log("lock_tail", 1, 0, 8'h5B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
